shift_reg_unit: RTL
===================

// Module: shift_reg_unit
// PURPOSE
//   Parametrised universal register: WIDTH-bit storage with hold, parallel load, clear,
//   logical/arithmetic shift and rotate, plus a multi-cycle shift sequencer.
//   Sequencer applies a shift op 'amt' times with busy/done handshake.
//   Datapath building block for serial I/O, bit-serial ALUs and test structures.
// PARAMETERS
//   WIDTH      8     register width in bits (>= 2)
//   RESET_VAL  0     value loaded into q on reset (WIDTH bits)
//   AW         $clog2(WIDTH+1)  width of amt (derived localparam, not overridable)
// PORTS
//   clk     in   1      clock, all state updates on posedge
//   rst     in   1      asynchronous reset, active-high
//   en      in   1      single-cycle op enable (ignored while busy)
//   mode    in   3      op select: 0 HOLD, 1 LOAD, 2 CLR, 3 SHL, 4 SHR, 5 ASR, 6 ROL, 7 ROR
//   d       in   WIDTH  parallel load data
//   sin_l   in   1      serial in, enters bit 0 on SHL
//   sin_r   in   1      serial in, enters bit WIDTH-1 on SHR
//   start   in   1      launch multi-cycle run of shift op 'mode' for 'amt' cycles
//   amt     in   AW     shift count for run; values > WIDTH clamped to WIDTH
//   q       out  WIDTH  register contents
//   sout_l  out  1      q[WIDTH-1] (combinational from q)
//   sout_r  out  1      q[0] (combinational from q)
//   busy    out  1      high while a run is in progress
//   done    out  1      one-cycle pulse on the cycle after the last shift of a run
// BEHAVIOUR
//   Reset (async assert, sync-to-clk deassert by system): q=RESET_VAL, busy=0, done=0,
//     FSM=IDLE, internal counter=0. Reset mid-run aborts run; no done pulse.
//   Ops (one per edge): HOLD q=q; LOAD q=d; CLR q=0; SHL q={q[W-2:0],sin_l};
//     SHR q={sin_r,q[W-1:1]}; ASR q={q[W-1],q[W-1:1]}; ROL q={q[W-2:0],q[W-1]};
//     ROR q={q[0],q[W-1:1]}.
//   FSM states: IDLE, RUN.
//   IDLE: start=1 and mode in {3..7}: latch mode and clamped amt, go RUN, busy=1 next cycle.
//     If latched amt=0: stay IDLE, q unchanged, done=1 next cycle, busy stays 0.
//     start=1 with mode in {0..2}: start ignored; treated as en-path op if en=1.
//     start=0, en=1: perform mode op once, 1-cycle latency to q. en=0: hold.
//     start and en both 1 with shift mode: start wins (run), single op not also applied.
//   RUN: each edge applies latched op once, counter decrements; en, mode, start, amt ignored.
//     Serial inputs sampled live each RUN cycle.
//     On the edge applying the final shift: go IDLE, busy=0, done=1 for exactly one cycle.
//     Run of n shifts: busy high n cycles, q final n edges after start edge.
//   done is deasserted on every other cycle; start during the done cycle is accepted (IDLE).
//   Clamp: amt>WIDTH -> WIDTH; ROL/ROR by WIDTH returns original q; SHL by WIDTH
//     fills entirely from sin_l.
//   No X propagation from unused inputs: d ignored except LOAD.
// TESTING
//   Defaults WIDTH=8, RESET_VAL=8'h00 unless noted; outputs checked after each posedge.
//   1 Reset: assert rst mid-cycle (no clk edge) -> q=00, busy=0, done=0 immediately;
//     RESET_VAL=8'hA5 build -> q=A5.
//   2 Single ops: LOAD d=8'b1001_0110, then SHL sin_l=1 -> 2D; ASR -> 16;
//     ROR -> 0B; CLR -> 00.
//   3 Run: q=81, start mode=ROL amt=3 -> busy 3 cycles, q=0C, done pulse 1 cycle, busy=0.
//   4 Boundaries: amt=0 -> done next cycle, busy never 1, q unchanged;
//     amt=15 ROR on 5A -> clamped to 8, q=5A after 8 busy cycles.
//   5 Ignore while busy: during SHR run amt=4 on F0, toggle en/mode=LOAD/start
//     -> q=0F at done, no load.
//     start+en same cycle with mode=SHL -> run only.
//   6 Abort: rst asserted 2 cycles into ASR run amt=6 -> q=RESET_VAL, busy=0,
//     no done; fresh run afterwards completes normally.

Source files
------------

// File: rtl/shift_reg_unit.sv
// Universal WIDTH-bit register: hold/load/clear/shift/rotate per cycle, plus a
// sequencer that repeats one shift op 'amt' times with a busy/done handshake.
module shift_reg_unit #(
  parameter int unsigned        WIDTH     = 8,
  parameter logic [WIDTH-1:0]   RESET_VAL = '0,
  localparam int unsigned       AW        = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] d,
  input  logic             sin_l,
  input  logic             sin_r,
  input  logic             start,
  input  logic [AW-1:0]    amt,
  output logic [WIDTH-1:0] q,
  output logic             sout_l,
  output logic             sout_r,
  output logic             busy,
  output logic             done
);

  typedef enum logic [2:0] {
    OP_HOLD = 3'd0,
    OP_LOAD = 3'd1,
    OP_CLR  = 3'd2,
    OP_SHL  = 3'd3,
    OP_SHR  = 3'd4,
    OP_ASR  = 3'd5,
    OP_ROL  = 3'd6,
    OP_ROR  = 3'd7
  } op_t;

  typedef enum logic {IDLE, RUN} state_t;

  localparam logic [AW-1:0] AMT_MAX = AW'(WIDTH);

  state_t        state;
  op_t           op_r;
  logic [AW-1:0] cnt;
  logic [AW-1:0] amt_c;
  logic          is_shift;

  function automatic logic [WIDTH-1:0] apply_op(input op_t op, input logic [WIDTH-1:0] v,
                                                input logic sl, input logic sr,
                                                input logic [WIDTH-1:0] dv);
    logic [WIDTH-1:0] r;
    case (op)
      OP_LOAD: r = dv;
      OP_CLR:  r = '0;
      OP_SHL:  r = {v[WIDTH-2:0], sl};
      OP_SHR:  r = {sr, v[WIDTH-1:1]};
      OP_ASR:  r = {v[WIDTH-1], v[WIDTH-1:1]};
      OP_ROL:  r = {v[WIDTH-2:0], v[WIDTH-1]};
      OP_ROR:  r = {v[0], v[WIDTH-1:1]};
      default: r = v;
    endcase
    return r;
  endfunction

  always_comb begin
    amt_c    = (amt > AMT_MAX) ? AMT_MAX : amt;
    is_shift = (mode >= 3'd3);
  end

  assign sout_l = q[WIDTH-1];
  assign sout_r = q[0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      op_r  <= OP_HOLD;
      cnt   <= '0;
      q     <= RESET_VAL;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          // A shift-mode start takes priority over the single-op path.
          if (start && is_shift) begin
            if (amt_c == '0) begin
              done <= 1'b1;
            end else begin
              op_r  <= op_t'(mode);
              cnt   <= amt_c;
              busy  <= 1'b1;
              state <= RUN;
            end
          end else if (en) begin
            q <= apply_op(op_t'(mode), q, sin_l, sin_r, d);
          end
        end
        RUN: begin
          q   <= apply_op(op_r, q, sin_l, sin_r, d);
          cnt <= cnt - AW'(1);
          if (cnt == AW'(1)) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
